// File: rtl/exe_unit_w2.sv
// exe_unit_w2: width-parametrised ALU with single-cycle ops and iterative MUL/DIV behind a valid/ready handshake.
// Optional macro EXE_UNIT_W2_SAT_EN makes ADD/SUB saturate on signed overflow instead of wrapping.
module exe_unit_w2 #(
  parameter int m = 8,
  parameter int n = 3
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [n-1:0] i_oper,
  input  logic [m-1:0] i_argA,
  input  logic [m-1:0] i_argB,
  output logic         o_valid,
  output logic [m-1:0] o_result,
  output logic [3:0]   o_status
);
  localparam int CW = $clog2(m + 1);
  localparam logic [m-1:0] MW = m'(m);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state_q, state_d;
  logic [m-1:0] hi_q, hi_d, lo_q, lo_d, b_q, b_d, res_q, res_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0] stat_q, stat_d;
  logic div_q, div_d;
  logic accept, iterative, busy, last, upd;
  logic [m-1:0] add_r, sub_r, add_f, sub_f, sc_res, it_hi, it_lo, r;
  logic add_v, sub_v, shl_e;
  logic [1:0] sc_ev, fin_ev, e;
  logic [m:0] mul_s, div_sh, div_df;
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      b_q     <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      stat_q  <= '0;
      div_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      stat_q  <= stat_d;
      div_q   <= div_d;
    end
  end
  always_comb begin
    state_d = state_q == BUSY ? (last ? DONE : BUSY) :
              accept ? (iterative ? BUSY : DONE) : IDLE;
  end
  always_comb begin
    o_ready  = state_q != BUSY;
    o_valid  = state_q == DONE;
    o_result = res_q;
    o_status = stat_q;
  end
  always_comb begin
    add_r = i_argA + i_argB;
    sub_r = i_argA - i_argB;
    add_v = (i_argA[m-1] == i_argB[m-1]) && (add_r[m-1] != i_argA[m-1]);
    sub_v = (i_argA[m-1] != i_argB[m-1]) && (sub_r[m-1] != i_argA[m-1]);
    shl_e = i_argB >= MW;
  end
`ifdef EXE_UNIT_W2_SAT_EN
  logic [m-1:0] sat_a;
  // Overflow direction follows A's sign for both ADD and SUB.
  always_comb begin
    sat_a = i_argA[m-1] ? {1'b1, {(m-1){1'b0}}} : {1'b0, {(m-1){1'b1}}};
    add_f = add_v ? sat_a : add_r;
    sub_f = sub_v ? sat_a : sub_r;
  end
`else
  always_comb begin
    add_f = add_r;
    sub_f = sub_r;
  end
`endif
  always_comb begin
    accept    = i_valid && o_ready;
    iterative = i_oper[2:1] == 2'b11;
    sc_res = i_oper == 3'd0 ? add_f :
             i_oper == 3'd1 ? sub_f :
             i_oper == 3'd2 ? i_argA & i_argB :
             i_oper == 3'd3 ? i_argA | i_argB :
             i_oper == 3'd4 ? i_argA ^ i_argB :
             shl_e ? '0 : i_argA << i_argB;
    sc_ev = {i_oper == 3'd5 && shl_e, (i_oper == 3'd0 && add_v) || (i_oper == 3'd1 && sub_v)};
  end
  // MUL keeps {hi,lo} as partial product / multiplier; DIV keeps them as remainder / dividend-quotient.
  always_comb begin
    mul_s  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    div_sh = {hi_q, lo_q[m-1]};
    div_df = div_sh - {1'b0, b_q};
    it_hi  = div_q ? (div_df[m] ? div_sh[m-1:0] : div_df[m-1:0]) : mul_s[m:1];
    it_lo  = div_q ? {lo_q[m-2:0], ~div_df[m]} : {mul_s[0], lo_q[m-1:1]};
    fin_ev = div_q ? {b_q == '0, 1'b0} : {1'b0, |it_hi};
  end
  always_comb begin
    busy   = state_q == BUSY;
    last   = busy && cnt_q == CW'(1);
    upd    = (accept && !iterative) || last;
    r      = accept ? sc_res : it_lo;
    e      = accept ? sc_ev : fin_ev;
    div_d  = accept ? i_oper[0] : div_q;
    hi_d   = accept ? '0 : busy ? it_hi : hi_q;
    lo_d   = accept ? i_argA : busy ? it_lo : lo_q;
    b_d    = accept ? i_argB : b_q;
    cnt_d  = accept ? CW'(m) : busy ? cnt_q - CW'(1) : cnt_q;
    res_d  = upd ? r : res_q;
    stat_d = upd ? {e, r[m-1], r == '0} : stat_q;
  end
endmodule

// File: tb/tb_exe_unit_w2.sv
// tb_exe_unit_w2: directed self-checking bench for exe_unit_w2 at m=8.
module tb_exe_unit_w2;
  logic i_clk = 1'b0;
  logic i_rst, i_valid, o_ready, o_valid;
  logic [2:0] i_oper;
  logic [7:0] i_argA, i_argB, o_result;
  logic [3:0] o_status;
  int tests_run = 0;
  int fails = 0;
`ifdef EXE_UNIT_W2_SAT_EN
  localparam logic [7:0] ADD_R = 8'h7F;
  localparam logic [3:0] ADD_S = 4'b0100;
  localparam logic [7:0] SUB_R = 8'h80;
  localparam logic [3:0] SUB_S = 4'b0110;
`else
  localparam logic [7:0] ADD_R = 8'h80;
  localparam logic [3:0] ADD_S = 4'b0110;
  localparam logic [7:0] SUB_R = 8'h7F;
  localparam logic [3:0] SUB_S = 4'b0100;
`endif
  exe_unit_w2 #(.m(8), .n(3)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_oper(i_oper), .i_argA(i_argA), .i_argB(i_argB),
    .o_valid(o_valid), .o_result(o_result), .o_status(o_status)
  );
  always #5 i_clk = ~i_clk;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask
  task automatic accept(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    i_oper = op; i_argA = a; i_argB = b; i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
  endtask
  task automatic test_reset;
    i_rst = 1'b1; i_valid = 1'b0; i_oper = '0; i_argA = '0; i_argB = '0;
    tick(); tick();
    i_rst = 1'b0;
    tests_run++; if (o_ready !== 1'b1) begin fails++; $display("FAIL reset ready: got %b want 1", o_ready); end
    tests_run++; if (o_valid !== 1'b0) begin fails++; $display("FAIL reset valid: got %b want 0", o_valid); end
    tests_run++; if ({o_result, o_status} !== 12'h000) begin fails++; $display("FAIL reset outputs: got %h/%b want 00/0000", o_result, o_status); end
  endtask
  task automatic test_single(input string nm, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                             input logic [7:0] er, input logic [3:0] es);
    accept(op, a, b);
    tests_run++; if (o_valid !== 1'b1) begin fails++; $display("FAIL %s valid: got %b want 1", nm, o_valid); end
    tests_run++; if (o_result !== er) begin fails++; $display("FAIL %s result: got %h want %h", nm, o_result, er); end
    tests_run++; if (o_status !== es) begin fails++; $display("FAIL %s status: got %b want %b", nm, o_status, es); end
    tick();
    tests_run++; if (o_valid !== 1'b0 || o_result !== er) begin fails++; $display("FAIL %s hold: got valid %b result %h want 0/%h", nm, o_valid, o_result, er); end
  endtask
  task automatic test_iter(input string nm, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] er, input logic [3:0] es);
    int bad = 0;
    accept(op, a, b);
    for (int i = 0; i < 8; i++) begin
      if (o_ready !== 1'b0 || o_valid !== 1'b0) bad++;
      i_argA = ~a; i_argB = b + 8'd1; i_oper = ~op;
      tick();
    end
    tests_run++; if (bad != 0) begin fails++; $display("FAIL %s busy: got %0d cycles not busy want 0", nm, bad); end
    tests_run++; if (o_valid !== 1'b1 || o_ready !== 1'b1) begin fails++; $display("FAIL %s done: got valid %b ready %b want 1/1", nm, o_valid, o_ready); end
    tests_run++; if (o_result !== er) begin fails++; $display("FAIL %s result: got %h want %h", nm, o_result, er); end
    tests_run++; if (o_status !== es) begin fails++; $display("FAIL %s status: got %b want %b", nm, o_status, es); end
    tick();
    tests_run++; if (o_valid !== 1'b0 || o_result !== er) begin fails++; $display("FAIL %s hold: got valid %b result %h want 0/%h", nm, o_valid, o_result, er); end
  endtask
  task automatic test_back_to_back;
    i_oper = 3'd4; i_argA = 8'hF0; i_argB = 8'h0F; i_valid = 1'b1;
    tick();
    i_oper = 3'd2;
    tests_run++; if (o_valid !== 1'b1 || o_ready !== 1'b1) begin fails++; $display("FAIL b2b first: got valid %b ready %b want 1/1", o_valid, o_ready); end
    tests_run++; if ({o_result, o_status} !== {8'hFF, 4'b0010}) begin fails++; $display("FAIL b2b xor: got %h/%b want ff/0010", o_result, o_status); end
    tick();
    i_valid = 1'b0;
    tests_run++; if (o_valid !== 1'b1 || o_ready !== 1'b1) begin fails++; $display("FAIL b2b second: got valid %b ready %b want 1/1", o_valid, o_ready); end
    tests_run++; if ({o_result, o_status} !== {8'h00, 4'b0001}) begin fails++; $display("FAIL b2b and: got %h/%b want 00/0001", o_result, o_status); end
    tick();
    tests_run++; if (o_valid !== 1'b0) begin fails++; $display("FAIL b2b end: got valid %b want 0", o_valid); end
  endtask
  task automatic test_reset_abort;
    int pulses = 0;
    accept(3'd6, 8'd13, 8'd11);
    tick(); tick();
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    tests_run++; if (o_ready !== 1'b1 || o_valid !== 1'b0) begin fails++; $display("FAIL abort state: got ready %b valid %b want 1/0", o_ready, o_valid); end
    tests_run++; if ({o_result, o_status} !== 12'h000) begin fails++; $display("FAIL abort outputs: got %h/%b want 00/0000", o_result, o_status); end
    for (int i = 0; i < 12; i++) begin
      if (o_valid !== 1'b0) pulses++;
      tick();
    end
    tests_run++; if (pulses != 0) begin fails++; $display("FAIL abort pulse: got %0d valid cycles want 0", pulses); end
  endtask
  initial begin
    test_reset();
    test_single("add", 3'd0, 8'h7F, 8'h01, ADD_R, ADD_S);
    test_single("sub", 3'd1, 8'h80, 8'h01, SUB_R, SUB_S);
    test_single("or", 3'd3, 8'h30, 8'h05, 8'h35, 4'b0000);
    test_single("shl", 3'd5, 8'h03, 8'd2, 8'h0C, 4'b0000);
    test_single("shl_big", 3'd5, 8'h03, 8'd8, 8'h00, 4'b1001);
    test_iter("mul", 3'd6, 8'd13, 8'd11, 8'h8F, 4'b0010);
    test_iter("mul_ovf", 3'd6, 8'h20, 8'h10, 8'h00, 4'b0101);
    test_iter("div", 3'd7, 8'd200, 8'd7, 8'h1C, 4'b0000);
    test_iter("div0", 3'd7, 8'd5, 8'd0, 8'hFF, 4'b1010);
    test_back_to_back();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end
endmodule
